// File: rtl/result_router_pkg.sv
// Shared types and constants for the result router and its FIFO.
package result_router_pkg;

    typedef enum logic [1:0] {
        DEST_RF   = 2'd0,
        DEST_DM   = 2'd1,
        DEST_OP   = 2'd2,
        DEST_DROP = 2'd3
    } dest_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        dest_t      dest;
        logic [7:0] data;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/route_fifo.sv
// Storage for routed entries: synchronous write, combinational head read.
module route_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
        end
    end

    assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/result_router.sv
// Routes result beats in acceptance order to register file, data memory or output port;
// Dest=3 beats are counted and discarded.
module result_router
    import result_router_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       InValid,
    output logic       InReady,
    input  logic [1:0] Dest,
    input  logic [7:0] Data,
    output logic       RfValid,
    input  logic       RfReady,
    output logic [7:0] RfData,
    output logic       DmValid,
    input  logic       DmReady,
    output logic [7:0] DmData,
    output logic       OpValid,
    input  logic       OpReady,
    output logic [7:0] OpData,
    output logic [7:0] DropCount
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready_q;
    logic [7:0]           drop_q;
    logic [ENTRY_W-1:0]   head_raw;
    entry_t               head;
    logic                 accept, drop_hit, push, pop, head_ready;

    assign InReady   = ready_q;
    assign DropCount = drop_q;
    assign accept    = InValid & ready_q;
    assign drop_hit  = accept & (dest_t'(Dest) == DEST_DROP);
    assign push      = accept & ~drop_hit;
    assign pop       = (state_q != EMPTY) & head_ready;
    assign head      = entry_t'(head_raw);

    route_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({Dest, Data}),
        .rdata_o (head_raw)
    );

    // Only the sink named by the head entry sees Valid/Data; other Readys are ignored.
    always_comb begin
        RfValid    = 1'b0;
        DmValid    = 1'b0;
        OpValid    = 1'b0;
        RfData     = 8'h00;
        DmData     = 8'h00;
        OpData     = 8'h00;
        head_ready = 1'b0;
        if (state_q != EMPTY) begin
            unique case (head.dest)
                DEST_RF: begin
                    RfValid    = 1'b1;
                    RfData     = head.data;
                    head_ready = RfReady;
                end
                DEST_DM: begin
                    DmValid    = 1'b1;
                    DmData     = head.data;
                    head_ready = DmReady;
                end
                DEST_OP: begin
                    OpValid    = 1'b1;
                    OpData     = head.data;
                    head_ready = OpReady;
                end
                DEST_DROP: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        case (state_q)
            EMPTY: begin
                if (push) state_d = (FULL_CNT == CW'(1)) ? FULL : PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && (count_q + 1'b1 == FULL_CNT)) begin
                    state_d = FULL;
                end else if (pop && !push && (count_q == CW'(1))) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) state_d = (FULL_CNT == CW'(1)) ? EMPTY : PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // InReady is registered, so a pop while FULL only reopens the slot a cycle later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
            count_q <= '0;
            ready_q <= 1'b0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (state_d != FULL);
            if (drop_hit && (drop_q != DROP_MAX)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_result_router.sv
// Directed table, corner-case sequences and a scoreboarded random stream for result_router.
module tb_result_router;

    localparam int DEPTH = 2;
    localparam logic [1:0] NONE = 2'd3;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       InValid, InReady;
    logic [1:0] Dest;
    logic [7:0] Data;
    logic       RfValid, RfReady, DmValid, DmReady, OpValid, OpReady;
    logic [7:0] RfData, DmData, OpData, DropCount;

    int checks = 0;
    int failures = 0;

    result_router #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .Dest      (Dest),
        .Data      (Data),
        .RfValid   (RfValid),
        .RfReady   (RfReady),
        .RfData    (RfData),
        .DmValid   (DmValid),
        .DmReady   (DmReady),
        .DmData    (DmData),
        .OpValid   (OpValid),
        .OpReady   (OpReady),
        .OpData    (OpData),
        .DropCount (DropCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       v;
        logic [1:0] dest;
        logic [7:0] data;
        logic [2:0] rdy;       // {rf, dm, op}
        logic       exp_rdy;
        logic [1:0] exp_sink;  // 0..2, or NONE
        logic [7:0] exp_data;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vec [10];

    // {InReady, RfValid, RfData, DmValid, DmData, OpValid, OpData, DropCount}
    function automatic logic [35:0] outs();
        return {InReady, RfValid, RfData, DmValid, DmData, OpValid, OpData, DropCount};
    endfunction

    function automatic logic [35:0] exp_word(input logic rdy, input logic [1:0] sink,
                                             input logic [7:0] d, input logic [7:0] drop);
        logic [35:0] w;
        w = '0;
        w[35] = rdy;
        w[7:0] = drop;
        case (sink)
            2'd0: begin w[34] = 1'b1; w[33:26] = d; end
            2'd1: begin w[25] = 1'b1; w[24:17] = d; end
            2'd2: begin w[16] = 1'b1; w[15:8] = d; end
            default: ;
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] x,
                         input logic [2:0] rdy);
        InValid = v;
        Dest    = d;
        Data    = x;
        RfReady = rdy[2];
        DmReady = rdy[1];
        OpReady = rdy[0];
    endtask

    logic [9:0]  q [$];
    logic [7:0]  mdrop;
    logic        any_valid;
    logic        m_rdy, m_pop;
    logic [1:0]  hsink;
    logic [7:0]  hdata;

    initial begin
        vec[0] = '{1'b1, 2'd0, 8'h5A, 3'b111, 1'b1, NONE, 8'h00, 8'd0};
        vec[1] = '{1'b0, 2'd0, 8'h00, 3'b100, 1'b1, 2'd0, 8'h5A, 8'd0};
        vec[2] = '{1'b0, 2'd0, 8'h00, 3'b000, 1'b1, NONE, 8'h00, 8'd0};
        vec[3] = '{1'b1, 2'd1, 8'hAA, 3'b000, 1'b1, NONE, 8'h00, 8'd0};
        vec[4] = '{1'b1, 2'd2, 8'hBB, 3'b000, 1'b1, 2'd1, 8'hAA, 8'd0};
        vec[5] = '{1'b1, 2'd0, 8'h11, 3'b001, 1'b0, 2'd1, 8'hAA, 8'd0};
        vec[6] = '{1'b0, 2'd0, 8'h00, 3'b001, 1'b0, 2'd1, 8'hAA, 8'd0};
        vec[7] = '{1'b0, 2'd0, 8'h00, 3'b010, 1'b0, 2'd1, 8'hAA, 8'd0};
        vec[8] = '{1'b1, 2'd3, 8'h00, 3'b001, 1'b1, 2'd2, 8'hBB, 8'd0};
        vec[9] = '{1'b0, 2'd0, 8'h00, 3'b000, 1'b1, NONE, 8'h00, 8'd1};

        Reset_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 3'b000);
        #3;
        check("reset_state", outs(), exp_word(1'b0, NONE, 8'h00, 8'd0));
        #14;
        Reset_n = 1'b1;
        #3;
        check("ready_before_edge", outs(), exp_word(1'b0, NONE, 8'h00, 8'd0));
        tick();
        check("ready_after_release", outs(), exp_word(1'b1, NONE, 8'h00, 8'd0));

        for (int i = 0; i < 10; i++) begin
            drive(vec[i].v, vec[i].dest, vec[i].data, vec[i].rdy);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  exp_word(vec[i].exp_rdy, vec[i].exp_sink, vec[i].exp_data, vec[i].exp_drop));
            tick();
        end

        // Push and pop together at occupancy 1.
        drive(1'b1, 2'd0, 8'h11, 3'b000);
        tick();
        drive(1'b1, 2'd1, 8'h22, 3'b100);
        #1;
        check("pp_head_rf", outs(), exp_word(1'b1, 2'd0, 8'h11, 8'd1));
        tick();
        drive(1'b1, 2'd2, 8'h33, 3'b000);
        #1;
        check("pp_new_head", outs(), exp_word(1'b1, 2'd1, 8'h22, 8'd1));
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b010);
        #1;
        check("pp_full_after_one", outs(), exp_word(1'b0, 2'd1, 8'h22, 8'd1));
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b001);
        #1;
        check("pp_tail", outs(), exp_word(1'b1, 2'd2, 8'h33, 8'd1));
        tick();

        // Drop counter saturation.
        any_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3, 8'(i), 3'b111);
            #1;
            any_valid = any_valid | RfValid | DmValid | OpValid;
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 3'b000);
        #1;
        check("drop_saturate", outs(), exp_word(1'b1, NONE, 8'h00, 8'd255));
        check("drop_no_valid", {35'd0, any_valid}, 36'd0);

        // Reset while full.
        drive(1'b1, 2'd0, 8'h44, 3'b000);
        tick();
        drive(1'b1, 2'd1, 8'h55, 3'b000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b000);
        #1;
        check("full_before_reset", outs(), exp_word(1'b0, 2'd0, 8'h44, 8'd255));
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset_async", outs(), exp_word(1'b0, NONE, 8'h00, 8'd0));
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("reset_released", outs(), exp_word(1'b0, NONE, 8'h00, 8'd0));
        tick();
        check("reset_ready", outs(), exp_word(1'b1, NONE, 8'h00, 8'd0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 8'h00, 3'b111);
            #1;
            check($sformatf("no_stale%0d", i), outs(), exp_word(1'b1, NONE, 8'h00, 8'd0));
            tick();
        end

        // Random stream against a queue model.
        mdrop = 8'd0;
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom),
                  3'($urandom_range(0, 7)));
            #1;
            m_rdy = (q.size() < DEPTH);
            hsink = NONE;
            hdata = 8'h00;
            if (q.size() > 0) begin
                hsink = q[0][9:8];
                hdata = q[0][7:0];
            end
            check("rand", outs(), exp_word(m_rdy, hsink, hdata, mdrop));
            m_pop = ((hsink == 2'd0) && RfReady) || ((hsink == 2'd1) && DmReady) ||
                    ((hsink == 2'd2) && OpReady);
            if (m_pop) void'(q.pop_front());
            if (InValid && m_rdy) begin
                if (Dest == 2'd3) begin
                    if (mdrop != 8'd255) mdrop = mdrop + 8'd1;
                end else begin
                    q.push_back({Dest, Data});
                end
            end
            tick();
        end

        for (int c = 0; c < DEPTH + 2; c++) begin
            drive(1'b0, 2'd0, 8'h00, 3'b111);
            #1;
            m_rdy = (q.size() < DEPTH);
            hsink = NONE;
            hdata = 8'h00;
            if (q.size() > 0) begin
                hsink = q[0][9:8];
                hdata = q[0][7:0];
                void'(q.pop_front());
            end
            check("drain", outs(), exp_word(m_rdy, hsink, hdata, mdrop));
            tick();
        end
        #1;
        check("drain_idle", outs(), exp_word(1'b1, NONE, 8'h00, mdrop));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_router.md
RESULT_ROUTER -- requirements
Module: result_router

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-003 SHALL have port InValid, input, 1 bit: an upstream result beat is offered.
REQ-004 SHALL have port InReady, output, 1 bit: the router accepts the beat this cycle.
REQ-005 SHALL have port Dest, input, 2 bits: beat destination. 0 = register file, 1 = data memory, 2 = output port, 3 = drop.
REQ-006 SHALL have port Data, input, 8 bits: the result value.
REQ-007 SHALL have ports RfValid (output, 1 bit), RfReady (input, 1 bit) and RfData (output, 8 bits): the register-file sink.
REQ-008 SHALL have ports DmValid (output, 1 bit), DmReady (input, 1 bit) and DmData (output, 8 bits): the data-memory sink.
REQ-009 SHALL have ports OpValid (output, 1 bit), OpReady (input, 1 bit) and OpData (output, 8 bits): the output-port sink.
REQ-010 SHALL have port DropCount, output, 8 bits: the number of Dest=3 beats accepted, saturating.
REQ-011 SHALL use parameter DEPTH, default 2: buffer entries (power of two, 2 or more).

Function
REQ-012 SHALL accept a beat in any cycle where InValid and InReady are both 1 at the rising edge.
REQ-013 SHALL drive InReady from registered state only; InReady = 1 when occupancy < DEPTH.
REQ-014 SHALL store each accepted beat with Dest 0..2 as a {Dest, Data} entry in a FIFO of DEPTH entries.
REQ-015 SHALL not store an accepted Dest=3 beat, and SHALL increment DropCount for it, holding at 255.
REQ-016 SHALL assert exactly the sink Valid selected by the head entry's Dest when occupancy > 0, with all other sink Valids at 0.
REQ-017 SHALL drive the selected sink's Data with the head Data, and the Data of non-selected sinks with 8'h00.
REQ-018 SHALL pop the head when the selected sink's Valid and Ready are both 1 at the edge; Ready of non-selected sinks SHALL be ignored.
REQ-019 SHALL present a beat accepted into an empty FIFO on its sink Valid at the next edge: latency 1 cycle, no combinational in-to-out path.
REQ-020 SHALL keep Valid and Data stable while a sink holds Ready low; there is no timeout.
REQ-021 SHALL deliver entries in strict acceptance order across all sinks; there is no reordering between destinations.
REQ-022 SHALL implement an occupancy state machine with states EMPTY, PARTIAL and FULL. Transitions:
- push only: EMPTY -> PARTIAL, or -> FULL when DEPTH reaches 1 entry short (PARTIAL -> FULL on the last free slot).
- pop only: the reverse transitions.
- push and pop together: state unchanged.
REQ-023 SHALL, when FULL, leave InReady at 0 even if a pop occurs that cycle; the slot reopens on the next cycle.
REQ-024 SHALL, on a simultaneous push and pop in PARTIAL, leave occupancy unchanged with the new entry at the tail.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL, for a Dest=3 beat accepted while a pop occurs, change only DropCount and the pop.

Reset
REQ-027 SHALL, while Reset_n is 0, asynchronously force: state to EMPTY; pointers to 0; DropCount to 0; InReady to 0; all sink Valids to 0; all sink Data to 8'h00.
REQ-028 SHALL assert InReady = 1 on the first edge after Reset_n rises.
REQ-029 SHALL discard buffered entries on an assertion of Reset_n mid-operation, with no partial delivery afterwards.

Structure
REQ-030 SHALL place in a shared package:
- a dest_t enum (DEST_RF=0, DEST_DM=1, DEST_OP=2, DEST_DROP=3);
- a state enum (EMPTY, PARTIAL, FULL);
- the DROP_MAX=255 constant.
REQ-031 SHALL implement the storage as one sub-module, route_fifo (synchronous-write, combinational-read FIFO parameterised by DEPTH and width 10).

Verification
REQ-032 The bench SHALL show: push {Dest=0, 8'h5A} with RfReady=1 -> RfValid=1 and RfData=5A one cycle later, popped that edge, DmValid=OpValid=0.
REQ-033 The bench SHALL show: push 1/AA then 2/BB with DmReady=OpReady=0 -> FULL and InReady=0; then raise OpReady only -> head stays AA on Dm and nothing pops.
REQ-034 The bench SHALL show: 300 consecutive Dest=3 beats -> DropCount=255 and all sink Valids remain 0.
REQ-035 The bench SHALL show: occupancy 1 with a push and pop in the same cycle -> occupancy stays 1 and the next head equals the pushed beat.
REQ-036 The bench SHALL show: FIFO FULL, then Reset_n pulsed low mid-cycle -> all Valids 0 immediately, InReady 1 after release, and no stale beat delivered.
REQ-037 The bench SHALL show: a random stream with random Ready over 10k cycles -> scoreboard confirms order, routing and no loss.
